// File: rtl/cheby_stream_pkg.sv
// cheby_stream_pkg: shared widths, header field layout and FSM encoding
// for the Chebyshev frame reader.
package cheby_stream_pkg;
   localparam int DATA_W_DEF  = 16;
   localparam int LEN_W_DEF   = 12;
   localparam int TAG_W_DEF   = 4;
   localparam int HDR_LEN_LSB = 0;
   typedef enum logic {S_HDR = 1'b0, S_DATA = 1'b1} state_t;
   function automatic int hdr_tag_lsb(input int data_w, input int tag_w);
      return data_w - tag_w;
   endfunction
endpackage

// File: rtl/cheby_prefetch_buf.sv
// cheby_prefetch_buf: 3-entry shift buffer in front of a read-latency-1 FIFO,
// tracking the in-flight word so occupancy never exceeds three.
module cheby_prefetch_buf #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              srst,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_head,
   output logic              o_nonempty
);
   logic [DATA_W-1:0] r_mem [3];
   logic [1:0]        r_count;
   logic              r_inflight;
   logic              w_pop;
   logic [1:0]        w_wr_idx;
   logic [DATA_W-1:0] w_shift [3];
   assign o_head     = r_mem[0];
   assign o_nonempty = r_count != 2'd0;
   assign w_pop      = i_pop && o_nonempty;
   assign w_wr_idx   = r_count - {1'b0, w_pop};
   assign w_shift    = '{r_mem[1], r_mem[2], r_mem[2]};
   // Reserve a slot for the word already requested, so a read never overfills.
   assign fifo_rd_en = !srst && !fifo_empty && (({1'b0, r_count} + {2'b0, r_inflight}) <= 3'd2);
   always_ff @(posedge clk) begin
      if (srst) begin
         r_count    <= '0;
         r_inflight <= 1'b0;
         for (int i = 0; i < 3; i++) r_mem[i] <= '0;
      end else begin
         r_inflight <= fifo_rd_en;
         r_count    <= r_count - {1'b0, w_pop} + {1'b0, r_inflight};
         for (int i = 0; i < 3; i++)
            r_mem[i] <= (r_inflight && w_wr_idx == 2'(i)) ? fifo_dout : w_pop ? w_shift[i] : r_mem[i];
      end
   end
endmodule

// File: rtl/cheby_frame_reader.sv
// cheby_frame_reader: splits a header+payload word stream into tagged frames
// with last-word marking for the Chebyshev compute stage.
module cheby_frame_reader
   import cheby_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int TAG_W  = TAG_W_DEF
) (
   input  logic              clk,
   input  logic              srst,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic [TAG_W-1:0]  m_tag,
   output logic              frame_done,
   output logic              busy
);
   state_t            r_state, w_next;
   logic [LEN_W-1:0]  r_remaining, w_len;
   logic [TAG_W-1:0]  r_tag, w_hdr_tag;
   logic [DATA_W-1:0] w_head;
   logic              w_nonempty, w_pop, w_hdr, w_beat, w_last_beat, w_data_st;
   cheby_prefetch_buf #(.DATA_W(DATA_W)) u_buf (
      .clk        (clk),
      .srst       (srst),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_nonempty (w_nonempty)
   );
   assign w_len     = w_head[HDR_LEN_LSB +: LEN_W];
   assign w_hdr_tag = w_head[hdr_tag_lsb(DATA_W, TAG_W) +: TAG_W];
   always_ff @(posedge clk) begin
      if (srst) begin
         r_state     <= S_HDR;
         r_remaining <= '0;
         r_tag       <= '0;
      end else begin
         r_state <= w_next;
         if (w_hdr) begin
            r_tag       <= w_hdr_tag;
            r_remaining <= w_len;
         end else if (w_beat) begin
            r_remaining <= r_remaining - LEN_W'(1);
         end
      end
   end
   always_comb begin
      w_next = w_hdr ? ((w_len != '0) ? S_DATA : S_HDR) : (w_last_beat ? S_HDR : r_state);
   end
   // Outputs are gated by srst so they read zero during the reset cycle itself.
   always_comb begin
      w_data_st   = !srst && r_state == S_DATA;
      w_hdr       = !srst && r_state == S_HDR && w_nonempty;
      m_valid     = w_data_st && w_nonempty;
      w_beat      = m_valid && m_ready;
      m_last      = m_valid && r_remaining == LEN_W'(1);
      w_last_beat = w_beat && m_last;
      w_pop       = w_hdr || w_beat;
      m_data      = w_data_st ? w_head : '0;
      m_tag       = srst ? '0 : r_tag;
      frame_done  = (w_hdr && w_len == '0) || w_last_beat;
      busy        = w_data_st;
   end
endmodule

// File: tb/tb_cheby_frame_reader.sv
// tb_cheby_frame_reader: scoreboard bench with a read-latency-1 FIFO model
// driving cheby_frame_reader.
module tb_cheby_frame_reader;
   localparam int DW = 16;
   localparam int TW = 4;
   logic          clk = 1'b0;
   logic          srst = 1'b1;
   logic          fifo_empty = 1'b1;
   logic          m_ready = 1'b0;
   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_rd_en, m_valid, m_last, frame_done, busy;
   logic [DW-1:0] m_data;
   logic [TW-1:0] m_tag;
   logic [DW-1:0]   src_q [$];
   logic [DW+TW:0]  exp_q [$];
   int n_chk = 0, n_err = 0;
   int exp_done = 0, got_done = 0, beats = 0;
   int gap_pct = 0, rdy_pct = 100;
   always #5 clk = ~clk;
   cheby_frame_reader dut (
      .clk        (clk),
      .srst       (srst),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .m_tag      (m_tag),
      .frame_done (frame_done),
      .busy       (busy)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic push_frame(input logic [3:0] tg, input logic [DW-1:0] pay [$]);
      src_q.push_back({tg, 12'(pay.size())});
      for (int i = 0; i < pay.size(); i++) begin
         src_q.push_back(pay[i]);
         exp_q.push_back({pay[i], tg, i == pay.size() - 1});
      end
      exp_done++;
   endtask
   // One clock: observe at negedge, then act as the upstream FIFO just after posedge.
   task automatic cyc();
      logic          rd;
      logic [DW-1:0] nxt;
      nxt = '0;
      @(negedge clk);
      if (m_valid && m_ready) begin
         beats++;
         if (exp_q.size() == 0) check("beat_extra", 1, 0);
         else check("beat", {m_data, m_tag, m_last}, exp_q.pop_front());
      end
      if (frame_done) got_done++;
      rd = fifo_rd_en;
      if (rd) nxt = src_q.pop_front();
      @(posedge clk);
      #1;
      if (rd) fifo_dout = nxt;
      fifo_empty = src_q.size() == 0 || $urandom_range(99) < gap_pct;
      m_ready    = $urandom_range(99) < rdy_pct;
   endtask
   task automatic drain(input string tag, input int budget);
      int k = 0;
      while ((exp_q.size() != 0 || got_done != exp_done) && k < budget) begin
         cyc();
         k++;
      end
      check({tag, "_timeout"}, 32'(k < budget), 1);
      check({tag, "_done"}, got_done, exp_done);
   endtask
   task automatic wait_valid(input int budget);
      int k = 0;
      while (!m_valid && k < budget) begin
         cyc();
         k++;
      end
      check("valid_timeout", m_valid, 1);
   endtask
   task automatic check_idle(input string tag);
      check({tag, "_rd"}, fifo_rd_en, 0);
      check({tag, "_valid"}, m_valid, 0);
      check({tag, "_last_done_busy"}, {m_last, frame_done, busy}, 0);
      check({tag, "_data_tag"}, {m_data, m_tag}, 0);
   endtask
   initial begin
      logic [DW-1:0] pl [$];
      int b0, popped0;
      repeat (3) cyc();
      src_q.push_back(16'h1001);
      fifo_empty = 1'b0;
      #1;
      check_idle("rst_hold");
      cyc();
      srst = 1'b0;
      src_q.delete();
      fifo_empty = 1'b1;
      #1;
      check_idle("rst_rel");
      // Basic frame of three payload words
      pl = '{16'h0AAA, 16'h0BBB, 16'h0CCC};
      push_frame(4'h5, pl);
      drain("f5", 100);
      // Zero-length frame followed by a single-word frame
      pl = {};
      push_frame(4'h2, pl);
      pl = '{16'h1234};
      push_frame(4'h3, pl);
      drain("f0f3", 100);
      // Downstream stall with the FIFO holding a 20-word frame
      pl = {};
      for (int i = 0; i < 20; i++) pl.push_back(DW'(16'h2000 + i));
      rdy_pct = 0;
      m_ready = 1'b0;
      push_frame(4'h6, pl);
      popped0 = src_q.size();
      wait_valid(20);
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("stall_valid", m_valid, 1);
         check("stall_hold", {m_data, m_tag, m_last}, exp_q[0]);
      end
      check("stall_rd", fifo_rd_en, 0);
      check("stall_popped", popped0 - src_q.size(), 4);
      rdy_pct = 100;
      drain("stall", 200);
      // Back-to-back frames: one bubble per header
      for (int f = 0; f < 2; f++) begin
         pl = {};
         for (int i = 0; i < 8; i++) pl.push_back(DW'(16'h3000 + f * 16 + i));
         push_frame(4'(8 + f), pl);
      end
      wait_valid(20);
      b0 = beats;
      repeat (17) cyc();
      check("tput_beats", beats - b0, 16);
      drain("tput", 50);
      // Reset in the middle of an L=5 frame
      pl = '{16'h4001, 16'h4002, 16'h4003, 16'h4004, 16'h4005};
      push_frame(4'hA, pl);
      b0 = beats;
      for (int k = 0; k < 50 && beats < b0 + 2; k++) cyc();
      check("mid_beats", beats - b0, 2);
      srst = 1'b1;
      #1;
      check_idle("mid_rst");
      cyc();
      srst = 1'b0;
      src_q.delete();
      exp_q.delete();
      exp_done = got_done;
      fifo_empty = 1'b1;
      #1;
      check_idle("mid_after");
      pl = '{16'h0777, 16'h0778};
      push_frame(4'h7, pl);
      drain("post_rst", 100);
      // Maximum-length frame
      pl = {};
      for (int i = 0; i < 4095; i++) pl.push_back(DW'(i * 7));
      push_frame(4'hF, pl);
      drain("maxlen", 6000);
      // Random frames with FIFO gaps and downstream back-pressure
      gap_pct = 30;
      rdy_pct = 60;
      for (int f = 0; f < 1000; f++) begin
         pl = {};
         for (int i = 0; i < int'($urandom_range(6)); i++) pl.push_back(DW'($urandom));
         push_frame(4'($urandom), pl);
      end
      drain("random", 60000);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
